prm_edge_mask_sched: RTL and testbench

- Sequences a bank of combinational PRM obstacle edge checkers (15-bit occupancy in, 1-bit edge_mask out) across one obstacle frame.
- The checker bank is external and organised as NUM_GROUPS groups of GROUP_W checkers, selected by a group index.
- The block accepts one occupancy word, walks every group, and captures each group's edge_mask bits after a fixed pipeline latency.
- It streams the per-group mask words to the roadmap search engine over a valid/ready channel.

---
 rtl/prm_edge_mask_sched_if.sv | 28 ++
 rtl/prm_edge_mask_sched.sv | 149 ++++++++++++++
 tb/tb_prm_edge_mask_sched.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/prm_edge_mask_sched_if.sv
// Occupancy-in / mask-out handshake bundle for prm_edge_mask_sched.
// The slave modport is the scheduler. The master modport is the environment that feeds it and drains it.
interface prm_edge_mask_sched_if #(
  parameter int NUM_GROUPS = 32,
  parameter int GROUP_W    = 16,
  parameter int OBS_W      = 15
);
  localparam int GW = $clog2(NUM_GROUPS);

  logic               obs_valid;
  logic               obs_ready;
  logic [OBS_W-1:0]   obs_data;
  logic               res_valid;
  logic               res_ready;
  logic [GROUP_W-1:0] res_data;
  logic [GW-1:0]      res_grp;
  logic               res_last;

  modport master (
    output obs_valid, obs_data, res_ready,
    input  obs_ready, res_valid, res_data, res_grp, res_last
  );

  modport slave (
    input  obs_valid, obs_data, res_ready,
    output obs_ready, res_valid, res_data, res_grp, res_last
  );
endinterface

// File: rtl/prm_edge_mask_sched.sv
// Walks an external bank of PRM edge checkers one group at a time for a latched occupancy word.
// It streams each group's edge_mask word out. Define PRM_EDGE_BLKCNT_EN to add a per-frame blocked-edge counter (blk_cnt).
module prm_edge_mask_sched #(
  parameter int NUM_GROUPS = 32,
  parameter int GROUP_W    = 16,
  parameter int OBS_W      = 15,
  parameter int CHK_LAT    = 1,
  localparam int GW        = $clog2(NUM_GROUPS)
) (
  input  logic                clk,
  input  logic                rst_n,
  prm_edge_mask_sched_if.slave bus,
  input  logic                abort,
  output logic [GW-1:0]       chk_grp,
  output logic [OBS_W-1:0]    chk_obs,
  input  logic [GROUP_W-1:0]  chk_mask,
  output logic                busy
`ifdef PRM_EDGE_BLKCNT_EN
  ,
  output logic [$clog2(NUM_GROUPS*GROUP_W+1)-1:0] blk_cnt
`endif
);

  localparam int LW = (CHK_LAT > 1) ? $clog2(CHK_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, PRESENT} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [GW-1:0]      grp_cnt;
  logic [LW-1:0]      lat_cnt;
  logic [GROUP_W-1:0] res_data_p1;
  logic [GW-1:0]      res_grp_p1;
  logic               res_last_p1;
  logic               vld_p1;
  logic               obs_rdy_c;
  logic               busy_c;
  logic               accept;
  logic               capture;

  assign accept  = (state == IDLE) && bus.obs_valid;
  assign capture = (state == WAIT) && (lat_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // abort overrides every non-IDLE transition, including a same-cycle handshake
  always_comb begin
    state_nxt = state;
    obs_rdy_c = 1'b0;
    busy_c    = 1'b1;
    vld_p1    = 1'b0;
    case (state)
      IDLE: begin
        obs_rdy_c = 1'b1;
        busy_c    = 1'b0;
        if (bus.obs_valid) state_nxt = ISSUE;
      end
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (lat_cnt == '0) state_nxt = PRESENT;
      PRESENT: begin
        vld_p1 = 1'b1;
        if (bus.res_ready) state_nxt = res_last_p1 ? IDLE : ISSUE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort && (state != IDLE)) state_nxt = IDLE;
  end

  assign bus.obs_ready = obs_rdy_c;
  assign bus.res_valid = vld_p1;
  assign bus.res_data  = res_data_p1;
  assign bus.res_grp   = res_grp_p1;
  assign bus.res_last  = res_last_p1;
  assign busy          = busy_c;

  // ---- issue / latency wait / capture stage ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_obs     <= '0;
      chk_grp     <= '0;
      grp_cnt     <= '0;
      lat_cnt     <= '0;
      res_data_p1 <= '0;
      res_grp_p1  <= '0;
      res_last_p1 <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            chk_obs <= bus.obs_data;
            grp_cnt <= '0;
          end
        end
        ISSUE: begin
          chk_grp <= grp_cnt;
          lat_cnt <= LW'(CHK_LAT - 1);
        end
        WAIT: begin
          if (lat_cnt != '0) begin
            lat_cnt <= lat_cnt - LW'(1);
          end else begin
            res_data_p1 <= chk_mask;
            res_grp_p1  <= grp_cnt;
            res_last_p1 <= (grp_cnt == GW'(NUM_GROUPS - 1));
          end
        end
        PRESENT: begin
          // the last group never increments, so grp_cnt cannot wrap inside a frame
          if (bus.res_ready && !res_last_p1) grp_cnt <= grp_cnt + GW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef PRM_EDGE_BLKCNT_EN
  localparam int BW      = $clog2(NUM_GROUPS*GROUP_W+1);
  localparam int BLK_MAX = NUM_GROUPS*GROUP_W;

  function automatic logic [BW-1:0] popcnt(input logic [GROUP_W-1:0] w);
    logic [BW-1:0] n;
    n = '0;
    for (int i = 0; i < GROUP_W; i++) n = n + BW'(w[i]);
    return n;
  endfunction

  function automatic logic [BW-1:0] sat_add(input logic [BW-1:0] a, input logic [BW-1:0] b);
    logic [BW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s > (BW+1)'(BLK_MAX)) return BW'(BLK_MAX);
    return s[BW-1:0];
  endfunction

  // ---- blocked-edge accumulation stage ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_cnt <= '0;
    end else if (accept || (abort && (state != IDLE))) begin
      blk_cnt <= '0;
    end else if (capture) begin
      blk_cnt <= sat_add(blk_cnt, popcnt(chk_mask));
    end
  end
`endif

endmodule

// File: tb/tb_prm_edge_mask_sched.sv
// Randomized self-checking bench for prm_edge_mask_sched with a mock checker bank and a frame-level reference model.
module tb_prm_edge_mask_sched;
  localparam int NG  = 4;
  localparam int GWD = 16;
  localparam int OW  = 15;
  localparam int LAT = 1;
  localparam int GW  = $clog2(NG);
  localparam int BW  = $clog2(NG*GWD+1);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            abort = 1'b0;
  logic [GW-1:0]   chk_grp;
  logic [OW-1:0]   chk_obs;
  logic [GWD-1:0]  chk_mask;
  logic            busy;
`ifdef PRM_EDGE_BLKCNT_EN
  logic [BW-1:0]   blk_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int mode_r   = 0;

  // reference model: frame in progress, latched word, next group owed, cycles since its issue
  bit             m_busy = 1'b0;
  logic [OW-1:0]  m_obs  = '0;
  int             m_grp  = 0;
  int             m_gap  = 0;
  int             m_blk  = 0;

  prm_edge_mask_sched_if #(.NUM_GROUPS(NG), .GROUP_W(GWD), .OBS_W(OW)) bus ();

  prm_edge_mask_sched #(.NUM_GROUPS(NG), .GROUP_W(GWD), .OBS_W(OW), .CHK_LAT(LAT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .abort    (abort),
    .chk_grp  (chk_grp),
    .chk_obs  (chk_obs),
    .chk_mask (chk_mask),
    .busy     (busy)
`ifdef PRM_EDGE_BLKCNT_EN
    ,
    .blk_cnt  (blk_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [GWD-1:0] mock(input int md, input logic [OW-1:0] obs, input logic [GW-1:0] g);
    case (md)
      0:       return {2'b00, g, 12'h0A5};
      1:       return {obs[3:0] ^ {2'b00, g}, obs[14:3]};
      2:       return 16'hFFFF;
      default: return 16'h0000;
    endcase
  endfunction

  assign chk_mask = mock(mode_r, chk_obs, chk_grp);

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [GWD-1:0] exp_word();
    return mock(mode_r, m_obs, GW'(m_grp));
  endfunction

  function automatic bit m_pres();
    return m_busy && (m_gap >= LAT + 1);
  endfunction

  task automatic compare();
    bit pres;
    pres = m_pres();
    check_val("obs_ready", bus.obs_ready, !m_busy);
    check_val("busy", busy, m_busy);
    check_val("res_valid", bus.res_valid, pres);
    if (m_busy) check_val("chk_obs", chk_obs, m_obs);
    if (m_busy && m_gap >= 1) check_val("chk_grp", chk_grp, m_grp);
    if (pres) begin
      check_val("res_data", bus.res_data, exp_word());
      check_val("res_grp", bus.res_grp, m_grp);
      check_val("res_last", bus.res_last, m_grp == NG - 1);
`ifdef PRM_EDGE_BLKCNT_EN
      if (m_grp == NG - 1) begin
        int s;
        s = m_blk + $countones(exp_word());
        if (s > NG*GWD) s = NG*GWD;
        check_val("blk_cnt", blk_cnt, s);
      end
`endif
    end
  endtask

  // one clock: decide events from pre-edge inputs, advance the model, then compare
  task automatic tick();
    bit pres, hs, acc, ab;
    logic [OW-1:0] od;
    pres = m_pres();
    hs   = pres && bus.res_ready;
    acc  = !m_busy && bus.obs_valid;
    ab   = abort;
    od   = bus.obs_data;
    @(posedge clk);
    #1;
    if (m_busy) begin
      if (hs) begin
        m_blk += $countones(exp_word());
        if (m_grp == NG - 1) m_busy = 1'b0;
        else begin
          m_grp++;
          m_gap = 0;
        end
      end else if (!pres) begin
        m_gap++;
      end
      if (ab) m_busy = 1'b0;
    end else if (acc) begin
      m_busy = 1'b1;
      m_obs  = od;
      m_grp  = 0;
      m_gap  = 0;
      m_blk  = 0;
    end
    compare();
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    bus.obs_valid = 1'b0;
    bus.res_ready = 1'b1;
    abort = 1'b0;
    while (m_busy && cyc < 400) begin
      tick();
      cyc++;
    end
    check_val("drain_timeout", cyc < 400, 1);
  endtask

  task automatic run_frame(input logic [OW-1:0] obs, input int md, input int stall_grp,
                           input int abort_grp, input bit keep_offer, input bit rnd_rdy);
    int st, cyc;
    bit pres;
    mode_r = md;
    bus.obs_valid = 1'b1;
    bus.obs_data  = obs;
    bus.res_ready = 1'b1;
    tick();
    if (!keep_offer) bus.obs_valid = 1'b0;
    st = 0;
    cyc = 0;
    while (m_busy && cyc < 400) begin
      pres = m_pres();
      if (keep_offer) bus.obs_data = OW'($urandom);
      bus.res_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pres && m_grp == stall_grp && st < 10) begin
        bus.res_ready = 1'b0;
        st++;
      end
      abort = m_busy && (m_grp == abort_grp) && (m_gap >= 1) && !pres;
      tick();
      cyc++;
    end
    abort = 1'b0;
    check_val("frame_timeout", cyc < 400, 1);
    if (keep_offer) begin
      bus.obs_data = 15'h2A5;
      tick();
      bus.obs_valid = 1'b0;
      drain();
    end
  endtask

  initial begin
    bus.obs_valid = 1'b0;
    bus.obs_data  = '0;
    bus.res_ready = 1'b0;
    #12;
    check_val("rst_obs_ready", bus.obs_ready, 1);
    check_val("rst_res_valid", bus.res_valid, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_chk_obs", chk_obs, 0);
    check_val("rst_res_last", bus.res_last, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run_frame(15'h4D2, 0, -1, -1, 1'b0, 1'b0);
    run_frame(15'h6B1, 1, 1, -1, 1'b0, 1'b0);
    run_frame(15'h155, 1, -1, -1, 1'b1, 1'b0);
    run_frame(15'h3C3, 0, -1, 2, 1'b0, 1'b0);
    run_frame(15'h0F0, 1, -1, -1, 1'b0, 1'b0);

    // asynchronous reset while presenting group 1
    mode_r = 1;
    bus.obs_valid = 1'b1;
    bus.obs_data  = 15'h7E1;
    bus.res_ready = 1'b1;
    tick();
    bus.obs_valid = 1'b0;
    for (int i = 0; i < 50 && !(m_pres() && m_grp == 1); i++) tick();
    check_val("reach_present_g1", m_pres() && m_grp == 1, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("arst_obs_ready", bus.obs_ready, 1);
    check_val("arst_res_valid", bus.res_valid, 0);
    check_val("arst_busy", busy, 0);
    check_val("arst_chk_obs", chk_obs, 0);
    check_val("arst_chk_grp", chk_grp, 0);
    check_val("arst_res_data", bus.res_data, 0);
    check_val("arst_res_grp", bus.res_grp, 0);
    check_val("arst_res_last", bus.res_last, 0);
    m_busy = 1'b0;
    m_blk  = 0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run_frame(15'h1111, 2, -1, -1, 1'b0, 1'b0);
    run_frame(15'h2222, 3, -1, -1, 1'b0, 1'b0);

    for (int f = 0; f < 12; f++)
      run_frame(OW'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), -1, 1'b0, 1'b1);

    for (int c = 0; c < 3000; c++) begin
      if (!m_busy && $urandom_range(0, 3) == 0) mode_r = $urandom_range(0, 3);
      bus.obs_valid = ($urandom_range(0, 2) == 0);
      bus.obs_data  = OW'($urandom);
      bus.res_ready = ($urandom_range(0, 3) != 0);
      abort         = ($urandom_range(0, 40) == 0);
      tick();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
